change_dispenser: RTL
=====================

# change_dispenser

Downstream stage of the vending machine. Consumes the one-cycle `soda` vend strobe and the 3-bit `change` amount it produces, then drives the can-release actuator and the coin hoppers through level/acknowledge handshakes. Change is paid in dimes and nickels, one coin per handshake. A one-deep pending slot absorbs a vend that arrives while a previous one is still being serviced.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 255: cycles an actuator output may stay asserted without an acknowledge before a fault is declared (1..255, 8-bit counter).

Ports:
- `clk`  in  1  system clock; all logic rising-edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `soda`  in  1  vend strobe from vending machine, one cycle wide.
- `change`  in  3  change owed in nickels (0..7 = 0..35 cents), valid when `soda`=1.
- `dime_empty`  in  1  dime hopper empty.
- `can_ack`  in  1  can-release actuator done.
- `coin_ack`  in  1  coin hopper ejected one coin.
- `can_rel`  out  1  release one can; level, held until ack.
- `nickel_ej`  out  1  eject one nickel; level, held until ack.
- `dime_ej`  out  1  eject one dime; level, held until ack.
- `busy`  out  1  job in progress or pending.
- `overflow`  out  1  sticky: a vend was dropped.
- `fault`  out  1  sticky: acknowledge timeout.

## Operation
- Registers: state, `owed` (3 bits), pending valid + pending change (3 bits), timeout counter (8 bits), `overflow`, `fault`.
- States: IDLE, CAN, PICK, NICK, DIME, FAULT. All actuator outputs are Moore-decoded from the state register:
  - `can_rel`=1 only in CAN.
  - `nickel_ej`=1 only in NICK.
  - `dime_ej`=1 only in DIME.
- IDLE:
  - If the pending slot is valid: load `owed` from it, clear it, go to CAN.
  - Else if `soda`=1: load `owed`=`change`, go to CAN.
- CAN: on `can_ack`, go to PICK.
- PICK (one cycle, all outputs low; guarantees a low gap between ejections):
  - `owed`=0: go to IDLE.
  - `CHANGE_DIME_EN` defined, `owed`>=2 and `dime_empty`=0: go to DIME.
  - Otherwise: go to NICK.
- NICK: on `coin_ack`, `owed`-=1, go to PICK.
- DIME: on `coin_ack`, `owed`-=2, go to PICK.
- `owed` never underflows; DIME is entered only when `owed`>=2.
- Acknowledges are sampled only in the matching state and ignored elsewhere.
- Pending slot, when `soda`=1 outside IDLE/FAULT:
  - Empty: store `change`.
  - Full: drop the vend, set `overflow`.
  - In IDLE with the slot valid and `soda`=1 together: the slot is consumed and the new vend is stored into the slot the same edge.
- `busy` = (state != IDLE) or pending valid.
- Timeout:
  - Counter clears on every state change and counts while in CAN/NICK/DIME.
  - When it reaches `ACK_TIMEOUT` without an ack: go to FAULT and set `fault`.
- FAULT: all actuator outputs 0, `soda` ignored, pending slot cleared, `busy`=0. Held until `rst`.
- Reset (async, any state, mid-handshake included):
  - State IDLE; `owed`, pending slot and counter cleared.
  - `can_rel`=`nickel_ej`=`dime_ej`=`busy`=`overflow`=`fault`=0.

## Timing
- `soda` sampled at edge k in IDLE: `can_rel`=1 and `busy`=1 from just after edge k.
- Ack sampled at edge m: the output drops after edge m; PICK occupies cycle m..m+1; the next ejection output rises after edge m+1.
- With acks returned combinationally in the same cycle, a job takes 2 cycles for the can plus 2 cycles per coin.
- `change`=0: can released, PICK, IDLE. No coin outputs toggle.
- FAULT entered exactly `ACK_TIMEOUT` cycles after the actuator output rises.

## Configuration
- `CHANGE_DIME_EN` defined: greedy dime-first payout; falls back to nickels when `dime_empty`=1 or `owed`=1.
- Not defined: nickels only; `dime_ej` tied 0 and `dime_empty` unused. Payout of n nickels takes n handshakes.

## Test plan
- `CHANGE_DIME_EN` on; `soda` with `change`=3, `dime_empty`=0, acks 2 cycles after each request -> `can_rel` pulse, then one `dime_ej`, then one `nickel_ej`; `busy` falls after the last PICK.
- `change`=0 -> only `can_rel` asserts; no coin outputs; `busy` returns 0 after 2 cycles following the ack.
- `dime_empty`=1, `change`=4 -> four distinct `nickel_ej` pulses, each separated by at least 1 low cycle.
- Second `soda` (`change`=1) during job 1 -> queued, serviced immediately after; a third `soda` while the slot is full -> `overflow`=1, dropped (no third can).
- `ACK_TIMEOUT`=8, `can_ack` never asserted -> `fault`=1 and `can_rel`=0 exactly 8 cycles after `can_rel` rose; later `soda` ignored until `rst`.
- `rst` asserted mid-NICK (asynchronously, between edges) -> all outputs 0 immediately; the next `soda` starts a clean job.

Source files
------------

// File: rtl/change_dispenser.sv
// Vend post-processor: releases one can, then pays change one coin per handshake.
// Optional greedy dime payout is enabled by defining CHANGE_DIME_EN.
module change_dispenser #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       soda,
  input  logic [2:0] change,
  input  logic       dime_empty,
  input  logic       can_ack,
  input  logic       coin_ack,
  output logic       can_rel,
  output logic       nickel_ej,
  output logic       dime_ej,
  output logic       busy,
  output logic       overflow,
  output logic       fault
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CAN   = 3'd1,
    PICK  = 3'd2,
    NICK  = 3'd3,
    DIME  = 3'd4,
    FAULT = 3'd5
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 32'd1);

  state_t     state_r, state_s;
  logic [2:0] owed_r, owed_s;
  logic       pend_vld_r, pend_vld_s;
  logic [2:0] pend_chg_r, pend_chg_s;
  logic [7:0] tmo_r, tmo_s;
  logic       ovf_s, flt_s;
  logic       dime_ok_s;

`ifdef CHANGE_DIME_EN
  assign dime_ok_s = ~dime_empty;
`else
  logic unused_dime_s;
  assign unused_dime_s = dime_empty;
  assign dime_ok_s     = 1'b0;
`endif

  // Next-state, payout bookkeeping, pending slot and ack timeout
  always_comb begin
    state_s    = state_r;
    owed_s     = owed_r;
    pend_vld_s = pend_vld_r;
    pend_chg_s = pend_chg_r;
    ovf_s      = overflow;
    flt_s      = fault;
    tmo_s      = 8'd0;

    // A vend arriving mid-job is parked in the slot, or dropped if it is full
    if (soda && (state_r != IDLE) && (state_r != FAULT)) begin
      if (pend_vld_r) begin
        ovf_s = 1'b1;
      end else begin
        pend_vld_s = 1'b1;
        pend_chg_s = change;
      end
    end else begin
      ovf_s = overflow;
    end

    case (state_r)
      IDLE: begin
        if (pend_vld_r) begin
          owed_s  = pend_chg_r;
          state_s = CAN;
          if (soda) begin
            pend_vld_s = 1'b1;
            pend_chg_s = change;
          end else begin
            pend_vld_s = 1'b0;
          end
        end else if (soda) begin
          owed_s  = change;
          state_s = CAN;
        end else begin
          state_s = IDLE;
        end
      end
      CAN: begin
        if (can_ack) begin
          state_s = PICK;
        end else if (tmo_r == TMO_LAST) begin
          state_s    = FAULT;
          flt_s      = 1'b1;
          pend_vld_s = 1'b0;
        end else begin
          state_s = CAN;
        end
      end
      PICK: begin
        if (owed_r == 3'd0) begin
          state_s = IDLE;
        end else if (dime_ok_s && (owed_r >= 3'd2)) begin
          state_s = DIME;
        end else begin
          state_s = NICK;
        end
      end
      NICK: begin
        if (coin_ack) begin
          owed_s  = owed_r - 3'd1;
          state_s = PICK;
        end else if (tmo_r == TMO_LAST) begin
          state_s    = FAULT;
          flt_s      = 1'b1;
          pend_vld_s = 1'b0;
        end else begin
          state_s = NICK;
        end
      end
      DIME: begin
        if (coin_ack) begin
          owed_s  = owed_r - 3'd2;
          state_s = PICK;
        end else if (tmo_r == TMO_LAST) begin
          state_s    = FAULT;
          flt_s      = 1'b1;
          pend_vld_s = 1'b0;
        end else begin
          state_s = DIME;
        end
      end
      FAULT: begin
        state_s    = FAULT;
        pend_vld_s = 1'b0;
      end
      default: begin
        state_s    = IDLE;
        pend_vld_s = 1'b0;
      end
    endcase

    if (state_s != state_r) begin
      tmo_s = 8'd0;
    end else if ((state_r == CAN) || (state_r == NICK) || (state_r == DIME)) begin
      tmo_s = tmo_r + 8'd1;
    end else begin
      tmo_s = 8'd0;
    end
  end

  // State and outputs registered together; outputs decode the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      owed_r     <= 3'd0;
      pend_vld_r <= 1'b0;
      pend_chg_r <= 3'd0;
      tmo_r      <= 8'd0;
      overflow   <= 1'b0;
      fault      <= 1'b0;
      can_rel    <= 1'b0;
      nickel_ej  <= 1'b0;
      dime_ej    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_s;
      owed_r     <= owed_s;
      pend_vld_r <= pend_vld_s;
      pend_chg_r <= pend_chg_s;
      tmo_r      <= tmo_s;
      overflow   <= ovf_s;
      fault      <= flt_s;
      can_rel    <= (state_s == CAN);
      nickel_ej  <= (state_s == NICK);
      dime_ej    <= (state_s == DIME);
      busy       <= ((state_s != IDLE) && (state_s != FAULT)) || pend_vld_s;
    end
  end

endmodule
